spi_register_word_writer: RTL and testbench
===========================================

SPI_REGISTER_WORD_WRITER -- requirements
Module: spi_register_word_writer

Interface
REQ-001 SHALL have parameter WORD_BYTES, default 4: bytes per assembled word; legal range 1..8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: words buffered; power of two, 2..16.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clock  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  high for the whole SPI transaction addressing this register.
REQ-007 data_in  input  8  received byte from SPI peripheral.
REQ-008 data_in_valid  input  1  one-cycle strobe per received byte.
REQ-009 word_out  output  8*WORD_BYTES  head-of-FIFO word.
REQ-010 word_out_valid  output  1  FIFO not empty.
REQ-011 word_out_ready  input  1  consumer accepts word_out.
REQ-012 fill_level  output  $clog2(FIFO_DEPTH)+1  words currently held.
REQ-013 overflow  output  1  sticky: a completed word was dropped.

Function
REQ-014 Assembler SHALL have two states: IDLE, COLLECT.
REQ-015 IDLE -> COLLECT SHALL occur only on a cycle where enable is high and was low the previous cycle (rising edge).
REQ-016 COLLECT -> IDLE SHALL occur on any cycle where enable is low.
REQ-017 In COLLECT, each data_in_valid SHALL shift data_in in MSB-first (first byte lands in word bits [8*WORD_BYTES-1 -: 8]) and increment byte_index.
REQ-018 data_in_valid SHALL be ignored in IDLE and when enable is low.
REQ-019 On the byte making byte_index reach WORD_BYTES, the word SHALL be pushed and byte_index wrapped to 0; assembly continues in the same transaction.
REQ-020 Leaving COLLECT with 0 < byte_index < WORD_BYTES SHALL discard the partial word and clear byte_index; no push.
REQ-021 Push latency: word_out_valid SHALL assert the cycle after the completing data_in_valid when the FIFO was empty.
REQ-022 FIFO SHALL be first-word-fall-through; a pop occurs on a cycle with word_out_valid and word_out_ready both high.
REQ-023 word_out SHALL stay stable while word_out_valid is high and word_out_ready is low.
REQ-024 word_out_ready while word_out_valid is low SHALL have no effect.
REQ-025 A push when full SHALL be accepted if a pop occurs the same cycle; fill_level unchanged.
REQ-026 A push when full without a same-cycle pop SHALL drop the new word, keep FIFO contents, and set overflow.
REQ-027 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave fill_level unchanged.
REQ-028 fill_level SHALL be registered and exact every cycle, 0..FIFO_DEPTH.
REQ-029 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 overflow SHALL clear only on reset.

Reset
REQ-031 reset SHALL force: state IDLE, byte_index 0, assembly register 0, FIFO empty, word_out 0, word_out_valid 0, fill_level 0, overflow 0.
REQ-032 Previous-enable register SHALL reset to 1, so reset asserted mid-transaction requires enable to fall and re-rise before collection resumes.
REQ-033 reset SHALL override all simultaneous data_in_valid, push and pop events.

Structure
REQ-034 Shared package spi_register_pkg SHALL hold the assembler state enum and the default WORD_BYTES/FIFO_DEPTH constants.
REQ-035 FIFO SHALL be a sub-module spi_register_fifo (sync, FWFT, width/depth parameters, full/empty/level outputs).
REQ-036 No combinational path SHALL exist from data_in/data_in_valid to any output.

Verification
REQ-037 Defaults, enable rise, bytes 0x12,0x34,0x56,0x78 -> next cycle word_out=0x12345678, word_out_valid=1, fill_level=1.
REQ-038 Enable rise, bytes 0xAA,0xBB, enable fall, rise, bytes 0x01,0x02,0x03,0x04 -> single word 0x01020304; 0xAABB never appears.
REQ-039 ready held 0, five complete words 1..5 -> fill_level=4, overflow=1, pops return 1,2,3,4 then word_out_valid=0.
REQ-040 FIFO full, ready=1 on the completing-byte cycle -> word accepted, fill_level stays 4, overflow=0.
REQ-041 reset pulsed after 2 bytes with enable held high, then 4 bytes -> no word pushed; after enable fall/rise, 4 bytes -> one word.
REQ-042 WORD_BYTES=1, enable high, bytes 0xC3,0x3C back-to-back, ready=1 -> two words 0xC3, 0x3C in order, fill_level peaks at 1.

Source files
------------

// File: rtl/spi_register_pkg.sv
// Shared types and default sizing for the SPI register word writer.
package spi_register_pkg;

    typedef enum logic {
        IDLE,
        COLLECT
    } asm_state_t;

    localparam int DEFAULT_WORD_BYTES = 4;
    localparam int DEFAULT_FIFO_DEPTH = 4;

endpackage

// File: rtl/spi_register_fifo.sv
// Synchronous first-word-fall-through FIFO with exact registered level.
module spi_register_fifo
    import spi_register_pkg::*;
#(
    parameter int WIDTH = 8 * DEFAULT_WORD_BYTES,
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a word when the head leaves this cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push && !reset) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (do_pop && !do_push) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_register_word_writer.sv
// Assembles SPI bytes MSB-first into words and queues them in a FIFO.
module spi_register_word_writer
    import spi_register_pkg::*;
#(
    parameter int WORD_BYTES = DEFAULT_WORD_BYTES,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int W  = 8 * WORD_BYTES,
    localparam int LW = $clog2(FIFO_DEPTH) + 1,
    localparam int IW = $clog2(WORD_BYTES) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic [7:0]    data_in,
    input  logic          data_in_valid,
    output logic [W-1:0]  word_out,
    output logic          word_out_valid,
    input  logic          word_out_ready,
    output logic [LW-1:0] fill_level,
    output logic          overflow
);

    localparam logic [IW-1:0] LAST = IW'(WORD_BYTES - 1);

    asm_state_t      state;
    logic            prev_enable;
    logic [IW-1:0]   byte_index;
    logic [W-1:0]    shift_reg;
    logic [W+7:0]    shifted;
    logic            take;
    logic            push;
    logic            full;
    logic            empty;

    assign shifted = {shift_reg, data_in};
    assign take    = (state == COLLECT) && enable && data_in_valid;
    assign push    = take && (byte_index == LAST);
    assign word_out_valid = !empty;

    spi_register_fifo #(
        .WIDTH(W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock(clock),
        .reset(reset),
        .push(push),
        .push_data(shifted[W-1:0]),
        .pop(word_out_ready),
        .head(word_out),
        .full(full),
        .empty(empty),
        .level(fill_level)
    );

    // Reset leaves prev_enable high so an open transaction must re-rise.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            prev_enable <= 1'b1;
            byte_index  <= '0;
            shift_reg   <= '0;
        end else begin
            prev_enable <= enable;
            unique case (state)
                IDLE: begin
                    if (enable && !prev_enable) begin
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (!enable) begin
                        state      <= IDLE;
                        byte_index <= '0;
                        shift_reg  <= '0;
                    end else if (push) begin
                        byte_index <= '0;
                        shift_reg  <= '0;
                    end else if (take) begin
                        byte_index <= byte_index + 1'b1;
                        shift_reg  <= shifted[W-1:0];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push && full && !(word_out_ready && word_out_valid)) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_register_word_writer.sv
// Directed bench for the SPI register word writer (4-byte and 1-byte words).
module tb_spi_register_word_writer;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  data_in;
    logic        data_in_valid;
    logic [31:0] word_out;
    logic        word_out_valid;
    logic        word_out_ready;
    logic [2:0]  fill_level;
    logic        overflow;

    logic        en2;
    logic [7:0]  d2;
    logic        v2;
    logic [7:0]  w2;
    logic        wv2;
    logic        r2;
    logic [2:0]  lvl2;
    logic        ovf2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    spi_register_word_writer dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .data_in(data_in),
        .data_in_valid(data_in_valid),
        .word_out(word_out),
        .word_out_valid(word_out_valid),
        .word_out_ready(word_out_ready),
        .fill_level(fill_level),
        .overflow(overflow)
    );

    spi_register_word_writer #(
        .WORD_BYTES(1),
        .FIFO_DEPTH(4)
    ) dut1 (
        .clock(clock),
        .reset(reset),
        .enable(en2),
        .data_in(d2),
        .data_in_valid(v2),
        .word_out(w2),
        .word_out_valid(wv2),
        .word_out_ready(r2),
        .fill_level(lvl2),
        .overflow(ovf2)
    );

    typedef struct {
        logic        en;
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic        wv;
        logic [31:0] w;
        logic [2:0]  lvl;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drv(input logic e, input logic v, input logic [7:0] d,
                       input logic r);
        enable         = e;
        data_in_valid  = v;
        data_in        = d;
        word_out_ready = r;
        tick();
    endtask

    task automatic send_word(input logic [31:0] w, input logic r_last);
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 1'b1, w[31-8*i -: 8], (i == 3) ? r_last : 1'b0);
        end
    endtask

    task automatic add(input logic en, input logic v, input logic [7:0] d,
                       input logic rdy, input logic wv, input logic [31:0] w,
                       input logic [2:0] lvl, input logic ovf);
        vec_t x;
        x.en = en; x.v = v; x.d = d; x.rdy = rdy;
        x.wv = wv; x.w = w; x.lvl = lvl; x.ovf = ovf;
        vecs.push_back(x);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drv(1'b0, 1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        check("rst_valid", word_out_valid, 0);
        check("rst_word", word_out, 0);
        check("rst_level", fill_level, 0);
        check("rst_ovf", overflow, 0);
    endtask

    initial begin
        reset = 1'b1;
        enable = 0; data_in = 0; data_in_valid = 0; word_out_ready = 0;
        en2 = 0; d2 = 0; v2 = 0; r2 = 0;
        tick();
        tick();
        check("rst_valid", word_out_valid, 0);
        check("rst_word", word_out, 0);
        check("rst_level", fill_level, 0);
        check("rst_ovf", overflow, 0);
        check("rst1_valid", wv2, 0);
        check("rst1_level", lvl2, 0);
        reset = 1'b0;

        // basic word, then partial discard and re-rise
        add(0, 0, 8'h00, 0, 0, 32'h0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 32'h0, 0, 0);
        add(1, 1, 8'h12, 0, 0, 32'h0, 0, 0);
        add(1, 1, 8'h34, 0, 0, 32'h0, 0, 0);
        add(1, 1, 8'h56, 0, 0, 32'h0, 0, 0);
        add(1, 1, 8'h78, 0, 1, 32'h12345678, 1, 0);
        add(0, 0, 8'h00, 1, 0, 32'h0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 32'h0, 0, 0);
        add(1, 1, 8'hAA, 0, 0, 32'h0, 0, 0);
        add(1, 1, 8'hBB, 0, 0, 32'h0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 32'h0, 0, 0);
        add(1, 1, 8'hEE, 0, 0, 32'h0, 0, 0);
        add(1, 1, 8'h01, 0, 0, 32'h0, 0, 0);
        add(1, 1, 8'h02, 0, 0, 32'h0, 0, 0);
        add(1, 1, 8'h03, 0, 0, 32'h0, 0, 0);
        add(1, 1, 8'h04, 0, 1, 32'h01020304, 1, 0);
        add(1, 0, 8'h00, 0, 1, 32'h01020304, 1, 0);
        add(0, 0, 8'h00, 1, 0, 32'h0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 32'h0, 0, 0);
        add(0, 1, 8'hFF, 0, 0, 32'h0, 0, 0);

        foreach (vecs[i]) begin
            drv(vecs[i].en, vecs[i].v, vecs[i].d, vecs[i].rdy);
            check($sformatf("vec%0d_valid", i), word_out_valid, vecs[i].wv);
            check($sformatf("vec%0d_level", i), fill_level, vecs[i].lvl);
            check($sformatf("vec%0d_ovf", i), overflow, vecs[i].ovf);
            if (vecs[i].wv) begin
                check($sformatf("vec%0d_word", i), word_out, vecs[i].w);
            end
        end

        // overflow with ready held low
        drv(0, 0, 8'h00, 0);
        drv(1, 0, 8'h00, 0);
        for (int k = 1; k <= 5; k++) begin
            send_word(32'(k), 1'b0);
            check($sformatf("ovf_fill%0d", k), fill_level, (k > 4) ? 4 : k);
            check($sformatf("ovf_flag%0d", k), overflow, (k == 5));
            check($sformatf("ovf_head%0d", k), word_out, 1);
        end
        drv(0, 0, 8'h00, 0);
        check("ovf_hold", word_out, 1);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("ovf_pop%0d", k), word_out, k);
            drv(0, 0, 8'h00, 1);
            check($sformatf("ovf_lvl%0d", k), fill_level, 4 - k);
        end
        check("ovf_empty", word_out_valid, 0);
        check("ovf_sticky", overflow, 1);

        // full FIFO with simultaneous pop on the completing byte
        do_reset();
        drv(0, 0, 8'h00, 0);
        drv(1, 0, 8'h00, 0);
        for (int k = 1; k <= 4; k++) send_word(32'(k), 1'b0);
        check("full_lvl", fill_level, 4);
        send_word(32'd5, 1'b1);
        check("fullpp_lvl", fill_level, 4);
        check("fullpp_ovf", overflow, 0);
        check("fullpp_head", word_out, 2);
        drv(0, 0, 8'h00, 0);
        for (int k = 2; k <= 5; k++) begin
            check($sformatf("fullpp_pop%0d", k), word_out, k);
            drv(0, 0, 8'h00, 1);
        end
        check("fullpp_empty", word_out_valid, 0);

        // reset mid-transaction with enable held high
        drv(0, 0, 8'h00, 0);
        drv(1, 0, 8'h00, 0);
        drv(1, 1, 8'hA1, 0);
        drv(1, 1, 8'hA2, 0);
        reset = 1'b1;
        drv(1, 1, 8'hA3, 1);
        reset = 1'b0;
        check("midrst_valid", word_out_valid, 0);
        check("midrst_lvl", fill_level, 0);
        drv(1, 0, 8'h00, 0);
        send_word(32'h11223344, 1'b0);
        check("midrst_nopush", word_out_valid, 0);
        check("midrst_nolvl", fill_level, 0);
        drv(0, 0, 8'h00, 0);
        drv(1, 0, 8'h00, 0);
        send_word(32'hCAFEF00D, 1'b0);
        check("midrst_valid2", word_out_valid, 1);
        check("midrst_word2", word_out, 32'hCAFEF00D);
        check("midrst_lvl2", fill_level, 1);

        // single-byte words on the second instance
        en2 = 1'b1;
        tick();
        v2 = 1'b1; d2 = 8'hC3; r2 = 1'b1;
        tick();
        check("wb1_valid0", wv2, 1);
        check("wb1_word0", w2, 8'hC3);
        check("wb1_lvl0", lvl2, 1);
        d2 = 8'h3C;
        tick();
        check("wb1_valid1", wv2, 1);
        check("wb1_word1", w2, 8'h3C);
        check("wb1_lvl1", lvl2, 1);
        v2 = 1'b0;
        tick();
        check("wb1_empty", wv2, 0);
        check("wb1_lvl2", lvl2, 0);
        check("wb1_ovf", ovf2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
